// File: rtl/mpu341_pkg.sv
// Shared MPU341 definitions: loader state encoding, nibble/word widths, default address width.
package mpu341_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned PM_DATA_W = 8;
  localparam int unsigned PM_ADDR_W = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StChkHi,
    StChkLo,
    StDone,
    StErr
  } pm_loader_state_t;

  function automatic logic state_accepts_nibble(input pm_loader_state_t st);
    return st inside {StLenHi, StLenLo, StDatHi, StDatLo, StChkHi, StChkLo};
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// Packs a high/low nibble pair into a byte; o_byte_valid pulses on the low-nibble transfer.
module nibble_packer
  import mpu341_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NIBBLE_W-1:0]  i_nib,
  input  logic                 i_xfer,
  input  logic                 i_low,
  output logic [PM_DATA_W-1:0] o_byte,
  output logic                 o_byte_valid
);

  logic [NIBBLE_W-1:0] r_hi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
    end else if (i_xfer && !i_low) begin
      r_hi <= i_nib;
    end
  end

  // Byte is combinational so the top can act on the same edge as the low nibble.
  assign o_byte       = {r_hi, i_nib};
  assign o_byte_valid = i_xfer && i_low;

endmodule

// File: rtl/pm_loader.sv
// MPU341 program-memory loader: nibble stream -> 8-bit words -> program memory write port.
// Define PM_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module pm_loader
  import mpu341_pkg::*;
#(
  parameter int unsigned          ADDR_W    = PM_ADDR_W,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NIBBLE_W-1:0]  nib_in,
  input  logic                 nib_valid,
  output logic                 nib_ready,
  output logic                 pm_wr_en,
  output logic [ADDR_W-1:0]    pm_wr_addr,
  output logic [PM_DATA_W-1:0] pm_wr_data,
  output logic                 mpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [PM_DATA_W:0] MaxWords = {1'b1, {PM_DATA_W{1'b0}}};

  pm_loader_state_t     r_state;
  pm_loader_state_t     w_state_d;
  logic [PM_DATA_W:0]   r_count;
  logic [ADDR_W-1:0]    r_addr;
  logic [PM_DATA_W-1:0] w_byte;
  logic                 w_byte_valid;
  logic                 w_xfer;
  logic                 w_low;
  logic                 w_start_ok;
  logic                 w_last;

  assign w_xfer     = nib_valid && nib_ready;
  assign w_low      = r_state inside {StLenLo, StDatLo, StChkLo};
  assign w_start_ok = start && (r_state inside {StIdle, StDone, StErr});
  assign w_last     = (r_count == (PM_DATA_W+1)'(1));

  nibble_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_nib        (nib_in),
    .i_xfer       (w_xfer),
    .i_low        (w_low),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid)
  );

`ifdef PM_LOADER_CHECKSUM_EN
  logic [PM_DATA_W-1:0] r_sum;
  logic                 r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (r_state == StDatLo && w_byte_valid) begin
      r_sum <= r_sum + w_byte;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone, StErr: if (start) w_state_d = StLenHi;
      StLenHi:               if (w_xfer) w_state_d = StLenLo;
      StLenLo:               if (w_byte_valid) w_state_d = StDatHi;
      StDatHi:               if (w_xfer) w_state_d = StDatLo;
      StDatLo: begin
        if (w_byte_valid) begin
`ifdef PM_LOADER_CHECKSUM_EN
          w_state_d = w_last ? StChkHi : StDatHi;
`else
          w_state_d = w_last ? StDone : StDatHi;
`endif
        end
      end
`ifdef PM_LOADER_CHECKSUM_EN
      StChkHi:               if (w_xfer) w_state_d = StChkLo;
      StChkLo:               if (w_byte_valid) w_state_d = (w_byte == r_sum) ? StDone : StErr;
`endif
      default:               w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      nib_ready  <= 1'b0;
      pm_wr_en   <= 1'b0;
      pm_wr_addr <= BASE_ADDR;
      pm_wr_data <= '0;
      mpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_count    <= '0;
      r_addr     <= BASE_ADDR;
`ifdef PM_LOADER_CHECKSUM_EN
      r_error    <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      nib_ready <= state_accepts_nibble(w_state_d);
      pm_wr_en  <= 1'b0;
      if (w_start_ok) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        mpu_hold <= 1'b1;
`ifdef PM_LOADER_CHECKSUM_EN
        r_error  <= 1'b0;
`endif
      end
      if (r_state == StLenLo && w_byte_valid) begin
        // A zero length byte means a full 256-word image.
        r_count <= (w_byte == '0) ? MaxWords : {1'b0, w_byte};
        r_addr  <= BASE_ADDR;
      end
      if (r_state == StDatLo && w_byte_valid) begin
        pm_wr_en   <= 1'b1;
        pm_wr_addr <= r_addr;
        pm_wr_data <= w_byte;
        r_addr     <= r_addr + ADDR_W'(1);
        r_count    <= r_count - (PM_DATA_W+1)'(1);
      end
      if (w_state_d == StDone && r_state != StDone) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        mpu_hold <= 1'b0;
      end
`ifdef PM_LOADER_CHECKSUM_EN
      if (w_state_d == StErr && r_state != StErr) begin
        busy    <= 1'b0;
        r_error <= 1'b1;
      end
`endif
    end
  end

endmodule
